// File: rtl/axis_mult_arbiter.sv
// Round-robin arbiter lending one AXI4-Stream multiplier wrapper to N requesters.
// A grant covers the request packet and the response packet that answers it.
module axis_mult_arbiter #(
    parameter int N         = 2,
    parameter int DSZ       = 8,
    parameter int REQ_BEATS = 8,
    parameter int RSP_BEATS = 8,
    parameter int IDW       = 3
) (
    input  logic               clk,
    input  logic               _rst,
    input  logic [N*DSZ-1:0]   req_tdata,
    input  logic [N-1:0]       req_tvalid,
    output logic [N-1:0]       req_tready,
    input  logic [N-1:0]       req_tlast,
    output logic [DSZ-1:0]     m_tdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic               m_tlast,
    input  logic [DSZ-1:0]     s_tdata,
    input  logic               s_tvalid,
    output logic               s_tready,
    input  logic               s_tlast,
    output logic [N*DSZ-1:0]   rsp_tdata,
    output logic [N-1:0]       rsp_tvalid,
    input  logic [N-1:0]       rsp_tready,
    output logic [N-1:0]       rsp_tlast,
    output logic [IDW-1:0]     grant_id,
    output logic               busy
);

    localparam int MAXB = (REQ_BEATS > RSP_BEATS) ? REQ_BEATS : RSP_BEATS;
    localparam int CW   = $clog2(MAXB) + 1;

    typedef enum logic [1:0] {IDLE, FWD, RET} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   grant_q;

    logic             gValid;
    logic [DSZ-1:0]   gData;
    logic             gLast;
    logic             gRspReady;
    logic             pickFound;
    logic [IDW-1:0]   pickIdx;
    logic [IDW-1:0]   ptrNext;
    logic             reqAtMax;
    logic             rspAtMax;
    logic             retLast;
    logic             fwdFire;
    logic             retFire;

    always_comb begin
        gValid    = 1'b0;
        gData     = '0;
        gLast     = 1'b0;
        gRspReady = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant_q == IDW'(i)) begin
                gValid    = req_tvalid[i];
                gData     = req_tdata[i*DSZ +: DSZ];
                gLast     = req_tlast[i];
                gRspReady = rsp_tready[i];
            end
        end
    end

    // Scan requesters starting at the priority pointer, wrapping at N.
    always_comb begin
        pickFound = 1'b0;
        pickIdx   = '0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!pickFound && req_tvalid[j] && (((int'(ptr_q) + k) % N) == j)) begin
                    pickFound = 1'b1;
                    pickIdx   = IDW'(j);
                end
            end
        end
    end

    assign reqAtMax = (cnt_q == CW'(REQ_BEATS - 1));
    assign rspAtMax = (cnt_q == CW'(RSP_BEATS - 1));
    assign retLast  = s_tlast | rspAtMax;
    assign ptrNext  = (grant_q == IDW'(N - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        req_tready = '0;
        m_tvalid   = 1'b0;
        m_tdata    = '0;
        m_tlast    = 1'b0;
        s_tready   = 1'b0;
        rsp_tvalid = '0;
        rsp_tlast  = '0;
        case (state_q)
            FWD: begin
                m_tvalid = gValid;
                m_tdata  = gData;
                m_tlast  = gLast | reqAtMax;
                for (int i = 0; i < N; i++) begin
                    if (grant_q == IDW'(i)) begin
                        req_tready[i] = m_tready;
                    end
                end
            end
            RET: begin
                s_tready = gRspReady;
                for (int i = 0; i < N; i++) begin
                    if (grant_q == IDW'(i)) begin
                        rsp_tvalid[i] = s_tvalid;
                        rsp_tlast[i]  = retLast;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign fwdFire   = m_tvalid & m_tready;
    assign retFire   = s_tvalid & s_tready;
    assign rsp_tdata = {N{s_tdata}};
    assign grant_id  = grant_q;
    assign busy      = (state_q != IDLE);

    // The pointer only moves when a response completes, so stalls never skew fairness.
    always_ff @(posedge clk) begin
        if (!_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pickFound) begin
                        grant_q <= pickIdx;
                        state_q <= FWD;
                    end
                end
                FWD: begin
                    if (fwdFire) begin
                        if (m_tlast) begin
                            cnt_q   <= '0;
                            state_q <= RET;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                RET: begin
                    if (retFire) begin
                        if (retLast) begin
                            cnt_q   <= '0;
                            ptr_q   <= ptrNext;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_mult_arbiter.sv
// Directed bench for axis_mult_arbiter: the bench plays requesters and the wrapper,
// queueing expected beats as they are accepted and popping them as the DUT emits them.
module tb_axis_mult_arbiter;

    localparam int N   = 2;
    localparam int DSZ = 8;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rstN;
    logic [N*DSZ-1:0] reqData;
    logic [N-1:0]     reqValid, reqReady, reqLast;
    logic [DSZ-1:0]   mData;
    logic             mValid, mReady, mLast;
    logic [DSZ-1:0]   sData;
    logic             sValid, sReady, sLast;
    logic [N*DSZ-1:0] rspData;
    logic [N-1:0]     rspValid, rspReady, rspLast;
    logic [2:0]       grantId;
    logic             busy;

    logic [31:0]      reqData4;
    logic [3:0]       reqValid4, reqReady4, reqLast4;
    logic [7:0]       mData4;
    logic             mValid4, mReady4, mLast4;
    logic [7:0]       sData4;
    logic             sValid4, sReady4, sLast4;
    logic [31:0]      rspData4;
    logic [3:0]       rspValid4, rspReady4, rspLast4;
    logic [2:0]       grantId4;
    logic             busy4;

    int    checks = 0;
    int    errors = 0;
    int    sent;
    beat_t expQ[$];

    always #5 clk = ~clk;

    axis_mult_arbiter #(.N(N), .DSZ(DSZ), .REQ_BEATS(8), .RSP_BEATS(8), .IDW(3)) dut (
        .clk(clk), ._rst(rstN),
        .req_tdata(reqData), .req_tvalid(reqValid), .req_tready(reqReady), .req_tlast(reqLast),
        .m_tdata(mData), .m_tvalid(mValid), .m_tready(mReady), .m_tlast(mLast),
        .s_tdata(sData), .s_tvalid(sValid), .s_tready(sReady), .s_tlast(sLast),
        .rsp_tdata(rspData), .rsp_tvalid(rspValid), .rsp_tready(rspReady), .rsp_tlast(rspLast),
        .grant_id(grantId), .busy(busy)
    );

    axis_mult_arbiter #(.N(4), .DSZ(8), .REQ_BEATS(8), .RSP_BEATS(8), .IDW(3)) dut4 (
        .clk(clk), ._rst(rstN),
        .req_tdata(reqData4), .req_tvalid(reqValid4), .req_tready(reqReady4), .req_tlast(reqLast4),
        .m_tdata(mData4), .m_tvalid(mValid4), .m_tready(mReady4), .m_tlast(mLast4),
        .s_tdata(sData4), .s_tvalid(sValid4), .s_tready(sReady4), .s_tlast(sLast4),
        .rsp_tdata(rspData4), .rsp_tvalid(rspValid4), .rsp_tready(rspReady4), .rsp_tlast(rspLast4),
        .grant_id(grantId4), .busy(busy4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rstN = 1'b0;
        reqValid = '0; reqLast = '0; mReady = 1'b0;
        sValid = 1'b0; sLast = 1'b0; rspReady = '0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
    endtask

    // Drives one request packet on a lane until the DUT closes it with m_tlast.
    task automatic applyStimulus(input int lane, input int nBeats, input bit lastAtEnd,
                                 input int stallPct, input logic [7:0] base,
                                 input bit idleFirst, output int sentBeats);
        int    idx = 0;
        int    cyc = 0;
        bit    done = 1'b0;
        beat_t b;
        while (!done && cyc < 400) begin
            @(negedge clk);
            reqValid[lane] = 1'b1;
            reqData[lane*DSZ +: DSZ] = base + 8'(idx);
            reqLast[lane] = lastAtEnd && (idx == nBeats - 1);
            mReady = ($urandom_range(99) >= stallPct);
            #1;
            if (idleFirst && cyc == 0) begin
                checkOutput("idleCycle_m_tvalid", mValid, 0);
                checkOutput("idleCycle_busy", busy, 0);
            end
            if (idleFirst && stallPct == 0 && cyc == 1)
                checkOutput("firstBeatLatency", reqReady[lane], 1);
            for (int j = 0; j < N; j++)
                if (j != lane) checkOutput("otherReqReady", reqReady[j], 0);
            if (reqValid[lane] && reqReady[lane]) begin
                b.data = base + 8'(idx);
                b.last = reqLast[lane] | (idx % 8 == 7);
                expQ.push_back(b);
                checkOutput("reqGrantId", grantId, lane);
            end
            if (mValid && mReady) begin
                checkOutput("mBeatQueued", expQ.size(), 1);
                if (expQ.size() > 0) begin
                    b = expQ.pop_front();
                    checkOutput("m_tdata", mData, b.data);
                    checkOutput("m_tlast", mLast, b.last);
                end
                if (mLast) done = 1'b1;
                idx++;
            end
            cyc++;
        end
        checkOutput("reqPacketDone", done, 1);
        @(negedge clk);
        reqValid[lane] = 1'b0;
        reqLast[lane] = 1'b0;
        mReady = 1'b0;
        sentBeats = idx;
    endtask

    // Plays the wrapper returning a response; abortAfter>0 leaves the packet open.
    task automatic driveResponse(input int lane, input int nBeats, input bit lastAtEnd,
                                 input int stallPct, input logic [7:0] base, input int abortAfter);
        int    idx = 0;
        int    cyc = 0;
        bit    done = 1'b0;
        beat_t b;
        while (!done && cyc < 400) begin
            @(negedge clk);
            sValid = ($urandom_range(99) >= stallPct / 2);
            sData  = base + 8'(idx);
            sLast  = lastAtEnd && (idx == nBeats - 1);
            for (int j = 0; j < N; j++)
                rspReady[j] = (j == lane) ? ($urandom_range(99) >= stallPct) : 1'($urandom_range(1));
            #1;
            for (int j = 0; j < N; j++)
                if (j != lane) checkOutput("otherRspValid", rspValid[j], 0);
            checkOutput("rspValidLane", rspValid[lane], sValid);
            checkOutput("sReadyLane", sReady, rspReady[lane]);
            if (sValid && sReady) begin
                b.data = base + 8'(idx);
                b.last = sLast | (idx == 7);
                expQ.push_back(b);
            end
            if (rspValid[lane] && rspReady[lane]) begin
                checkOutput("rspBeatQueued", expQ.size(), 1);
                if (expQ.size() > 0) begin
                    b = expQ.pop_front();
                    checkOutput("rsp_tdata", rspData[lane*DSZ +: DSZ], b.data);
                    checkOutput("rsp_tlast", rspLast[lane], b.last);
                end
                if (rspLast[lane]) done = 1'b1;
                idx++;
                if (abortAfter > 0 && idx == abortAfter) done = 1'b1;
            end
            cyc++;
        end
        checkOutput("rspPacketDone", done, 1);
        if (abortAfter == 0) begin
            @(negedge clk);
            sValid = 1'b0; sLast = 1'b0; rspReady = '0;
        end
    endtask

    task automatic txn4(input logic [3:0] mask, input int lane, input logic [7:0] base);
        int    idx = 0;
        int    cyc = 0;
        bit    done = 1'b0;
        beat_t b;
        logic [3:0] laneMask;
        laneMask = 4'(1 << lane);
        @(negedge clk);
        reqValid4 = mask; reqData4 = {4{8'hEE}}; reqLast4 = '0; mReady4 = 1'b1;
        while (!done && cyc < 100) begin
            @(negedge clk);
            reqData4[lane*8 +: 8] = base + 8'(idx);
            reqLast4[lane] = (idx == 7);
            #1;
            if (reqReady4[lane] && reqValid4[lane]) begin
                b.data = base + 8'(idx);
                b.last = (idx == 7);
                expQ.push_back(b);
                checkOutput("n4GrantId", grantId4, lane);
            end
            if (mValid4 && mReady4) begin
                checkOutput("n4BeatQueued", expQ.size(), 1);
                if (expQ.size() > 0) begin
                    b = expQ.pop_front();
                    checkOutput("n4_m_tdata", mData4, b.data);
                    checkOutput("n4_m_tlast", mLast4, b.last);
                end
                if (mLast4) done = 1'b1;
                idx++;
            end
            cyc++;
        end
        checkOutput("n4ReqDone", done, 1);
        @(negedge clk);
        reqValid4 = '0; reqLast4 = '0; mReady4 = 1'b0;
        done = 1'b0; idx = 0; cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            sValid4 = 1'b1; sData4 = 8'hD0 + 8'(idx); sLast4 = (idx == 7); rspReady4 = '1;
            #1;
            checkOutput("n4RspValidMask", rspValid4, laneMask);
            if (rspValid4[lane] && rspReady4[lane]) begin
                checkOutput("n4_rsp_tdata", rspData4[lane*8 +: 8], 8'hD0 + 8'(idx));
                checkOutput("n4_rsp_tlast", rspLast4[lane], (idx == 7));
                if (rspLast4[lane]) done = 1'b1;
                idx++;
            end
            cyc++;
        end
        checkOutput("n4RspDone", done, 1);
        @(negedge clk);
        sValid4 = 1'b0; sLast4 = 1'b0; rspReady4 = '0;
        #1;
        checkOutput("n4BusyAfter", busy4, 0);
    endtask

    initial begin
        reqData = '0; reqData4 = '0; reqValid4 = '0; reqLast4 = '0; mReady4 = 1'b0;
        sData = '0; sData4 = '0; sValid4 = 1'b0; sLast4 = 1'b0; rspReady4 = '0;
        doReset();
        #1;
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetGrant", grantId, 0);
        checkOutput("resetMValid", mValid, 0);
        checkOutput("resetMLast", mLast, 0);
        checkOutput("resetSReady", sReady, 0);
        checkOutput("resetReqReady", reqReady, 0);
        checkOutput("resetRspValid", rspValid, 0);
        checkOutput("resetRspLast", rspLast, 0);

        $display("[TB] single requester, bytes 1..8");
        applyStimulus(0, 8, 1'b1, 0, 8'h01, 1'b1, sent);
        checkOutput("t1Sent", sent, 8);
        #1;
        checkOutput("t1BusyInRet", busy, 1);
        driveResponse(0, 8, 1'b1, 0, 8'hA0, 0);
        #1;
        checkOutput("t1BusyAfter", busy, 0);
        reqValid = 2'b11; reqData = {8'h10, 8'hEE}; reqLast = '0;
        applyStimulus(1, 4, 1'b1, 0, 8'h10, 1'b0, sent);
        reqValid[0] = 1'b0;
        driveResponse(1, 8, 1'b1, 0, 8'hA8, 0);

        $display("[TB] simultaneous requests after reset");
        doReset();
        reqValid = 2'b11; reqData = {8'h30, 8'h20}; reqLast = '0;
        applyStimulus(0, 8, 1'b1, 0, 8'h20, 1'b0, sent);
        driveResponse(0, 8, 1'b1, 0, 8'hB0, 0);
        reqValid[0] = 1'b1; reqData[7:0] = 8'hEE;
        applyStimulus(1, 8, 1'b1, 0, 8'h30, 1'b0, sent);
        driveResponse(1, 8, 1'b1, 0, 8'hB8, 0);
        applyStimulus(0, 8, 1'b1, 0, 8'h40, 1'b0, sent);
        driveResponse(0, 8, 1'b1, 0, 8'hC0, 0);

        $display("[TB] random backpressure");
        applyStimulus(1, 8, 1'b1, 50, 8'h50, 1'b1, sent);
        driveResponse(1, 8, 1'b1, 50, 8'hC8, 0);
        applyStimulus(0, 8, 1'b1, 50, 8'h58, 1'b1, sent);
        driveResponse(0, 8, 1'b1, 50, 8'hD0, 0);

        $display("[TB] overlong packet cut at eight beats");
        applyStimulus(1, 10, 1'b0, 0, 8'h60, 1'b1, sent);
        checkOutput("t4FirstCut", sent, 8);
        driveResponse(1, 8, 1'b1, 0, 8'h70, 0);
        applyStimulus(1, 2, 1'b1, 0, 8'h68, 1'b1, sent);
        checkOutput("t4Remainder", sent, 2);
        driveResponse(1, 8, 1'b1, 0, 8'h78, 0);

        $display("[TB] reset during response beat 4");
        applyStimulus(1, 8, 1'b1, 0, 8'h80, 1'b1, sent);
        driveResponse(1, 8, 1'b1, 0, 8'h90, 3);
        @(negedge clk);
        rstN = 1'b0; sValid = 1'b1; sData = 8'h93; sLast = 1'b0; rspReady = 2'b11;
        reqValid = 2'b11; reqData = {8'hF0, 8'hE0}; reqLast = '0;
        #1;
        checkOutput("preResetRspValid", rspValid[1], 1);
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checkOutput("postResetBusy", busy, 0);
        checkOutput("postResetGrant", grantId, 0);
        checkOutput("postResetSReady", sReady, 0);
        checkOutput("postResetRspValid", rspValid, 0);
        checkOutput("postResetReqReady", reqReady, 0);
        checkOutput("postResetMValid", mValid, 0);
        sValid = 1'b0; rspReady = '0;
        applyStimulus(0, 8, 1'b1, 0, 8'hE0, 1'b0, sent);
        reqValid[1] = 1'b0;
        driveResponse(0, 8, 1'b1, 0, 8'h40, 0);

        $display("[TB] four requesters, lane 3 repeating");
        txn4(4'b1000, 3, 8'h01);
        txn4(4'b1000, 3, 8'h11);
        txn4(4'b1001, 0, 8'h21);
        txn4(4'b1001, 3, 8'h31);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_mult_arbiter.md
Name: axis_mult_arbiter

Overview:
- Round-robin arbiter sharing one AXI4-Stream multiplier wrapper between N stream requesters.
- Grant is locked for a full transaction: the request packet (operand bytes) is forwarded to the shared wrapper, then the response packet (product bytes) is routed back to the same requester.
- Sits between N requester-side stream ports and the single wrapper stream pair (request toward wrapper, response from wrapper).

Parameters:
- N, 2, number of requesters (2..8).
- DSZ, 8, stream data width in bits.
- REQ_BEATS, 8, max request beats per packet (2*SZ/DSZ for SZ=32).
- RSP_BEATS, 8, response beats per packet.
- IDW, 3, width of grant index (>= clog2(N)).

Ports:
- clk  in  1  clock, all logic on rising edge.
- _rst  in  1  synchronous active-low reset, sampled on rising edge of clk.
- req_tdata  in  N*DSZ  requester i data in bits [i*DSZ +: DSZ].
- req_tvalid  in  N  per-requester valid.
- req_tready  out  N  per-requester ready.
- req_tlast  in  N  per-requester last.
- m_tdata  out  DSZ  request data to wrapper.
- m_tvalid  out  1  request valid to wrapper.
- m_tready  in  1  wrapper ready.
- m_tlast  out  1  request last to wrapper.
- s_tdata  in  DSZ  response data from wrapper.
- s_tvalid  in  1  response valid from wrapper.
- s_tready  out  1  response ready to wrapper.
- s_tlast  in  1  response last from wrapper.
- rsp_tdata  out  N*DSZ  response data to requesters; s_tdata replicated to all lanes.
- rsp_tvalid  out  N  per-requester response valid.
- rsp_tready  in  N  per-requester response ready.
- rsp_tlast  out  N  per-requester response last.
- grant_id  out  IDW  index of current owner.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, FWD, RET.
- Reset (_rst=0 at a posedge):
  - state=IDLE, grant_id=0, priority pointer ptr=0, beat counter cnt=0.
  - All outputs low except the data buses, which are don't-care but driven 0.
  - A reset mid-transaction abandons the transaction without completing handshakes; every ready/valid output is low on the following cycle.
- IDLE:
  - All req_tready, m_tvalid, s_tready and rsp_tvalid are 0.
  - When any req_tvalid is set, grant the first set bit scanning ptr, ptr+1, … mod N. Register grant_id; state -> FWD.
  - Latency: one idle cycle from req_tvalid to the first forwarded beat.
- FWD (combinational pass-through for g=grant_id):
  - m_tdata = req_tdata[g], m_tvalid = req_tvalid[g], req_tready[g] = m_tready; other req_tready = 0.
  - m_tlast = req_tlast[g] | (cnt == REQ_BEATS-1).
  - cnt increments on each m_tvalid&m_tready beat.
  - On the handshake beat with m_tlast=1: cnt -> 0, state -> RET.
  - A packet longer than REQ_BEATS is cut; the remaining beats form a new packet under a later grant.
- RET:
  - s_tready = rsp_tready[g], rsp_tvalid[g] = s_tvalid, rsp_tlast[g] = s_tlast | (cnt == RSP_BEATS-1).
  - All other rsp_tvalid and req_tready = 0.
  - Response beats arriving while not in RET are not accepted (s_tready=0).
  - On the handshake beat with the effective last: cnt -> 0, ptr -> (g+1) mod N, state -> IDLE.
- Fairness: ptr advances only on transaction completion. A requester waits at most N-1 transactions.
- Simultaneous requests in IDLE: resolved by ptr only. A request raised during FWD/RET waits for IDLE.
- Backpressure: any stall on m_tready or rsp_tready holds cnt and state. No data is buffered inside the block.
- Widths: cnt is clog2(max(REQ_BEATS,RSP_BEATS))+1 bits. ptr and grant_id wrap at N, not at 2^IDW.

Test Plan:
- Single requester 0 sends bytes 1..8 with tlast on the 8th; wrapper multiplies -> m_tdata sequence 1..8 with m_tlast on beat 8; 8 response beats appear only on rsp lane 0, rsp_tlast[0] on beat 8; then busy=0 and ptr=1.
- Requesters 0 and 1 assert valid in the same cycle after reset -> grant_id=0 first; on completion requester 1 is granted; a third transaction from 0 is granted only after 1 completes.
- Random m_tready and rsp_tready stalls (50%) during a transaction -> no beat lost or duplicated; byte order is preserved; cnt is frozen during stalls.
- Requester 1 sends 10 beats without tlast -> m_tlast forced on beat 8; beats 9–10 are forwarded in a later transaction after the response completes.
- _rst pulsed low during RET at response beat 4 -> next cycle state=IDLE, all valid/ready=0, grant_id=0; a new request is then granted normally.
- N=4: only requester 3 requests repeatedly -> granted every time, with ptr cycling to 0 after each transaction.
